// File: rtl/fairy_lsu.sv
`default_nettype none
// ============================================================================
// Module   : fairy_lsu
// Brief    : Load/store unit between execute and writeback. Issues one
//            byte-enabled request per memory instruction on a req/gnt +
//            rvalid bus, returns lane-aligned sign/zero-extended load data,
//            or passes the ALU result straight through.
// Options  : FAIRY_LSU_TIMEOUT_EN - bus timeout counter drives out_buserr
// Revision : 1.0 - initial release
// ============================================================================
module fairy_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_pc,
  input  logic [31:0]           in_inst,
  input  logic                  in_load,
  input  logic                  in_store,
  input  logic [1:0]            in_size,
  input  logic                  in_signed,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [DATA_W-1:0]     in_wdata,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_inst,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_unaligned,
  output logic                  out_buserr
);

  localparam int BYTES = DATA_W / 8;
  localparam int LSB   = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
  state_t state;

  logic              load_q;
  logic              sign_q;
  logic [1:0]        size_q;
  logic [LSB-1:0]    lane_q;
  logic [LSB-1:0]    in_lane;
  logic              accept;
  logic              is_mem;
  logic              misaligned;
  logic [BYTES-1:0]  be_n;
  logic [DATA_W-1:0] wdata_n;
  logic [DATA_W-1:0] lane_data;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] fault_addr;
  logic              tmo_hit;

  assign in_lane  = in_addr[LSB-1:0];
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  // flush beats a simultaneous capture
  assign accept   = in_valid && in_ready && !flush;
  assign is_mem   = in_load || in_store;

  // natural-alignment check; dword never fits a 32-bit bus
  always_comb begin
    misaligned = 1'b0;
    case (in_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = in_addr[0];
      2'd2:    misaligned = |in_addr[1:0];
      default: misaligned = (DATA_W == 32) || (|in_addr[2:0]);
    endcase
  end

  // byte enables and lane-replicated store data for the accepted access
  always_comb begin
    be_n    = '1;
    wdata_n = in_wdata;
    case (in_size)
      2'd0: begin
        be_n    = BYTES'(1) << in_lane;
        wdata_n = {BYTES{in_wdata[7:0]}};
      end
      2'd1: begin
        be_n    = BYTES'(3) << in_lane;
        wdata_n = {(BYTES/2){in_wdata[15:0]}};
      end
      2'd2: begin
        be_n    = BYTES'(15) << in_lane;
        wdata_n = {(DATA_W/32){in_wdata[31:0]}};
      end
      default: begin
        be_n    = '1;
        wdata_n = in_wdata;
      end
    endcase
  end

  // right-justify the addressed lane, then sign- or zero-extend it
  assign lane_data = mem_rdata >> {lane_q, 3'b000};
  always_comb begin
    load_data = lane_data;
    case (size_q)
      2'd0: load_data = (sign_q && lane_data[7])
                        ? (lane_data | ~DATA_W'(8'hFF))
                        : (lane_data &  DATA_W'(8'hFF));
      2'd1: load_data = (sign_q && lane_data[15])
                        ? (lane_data | ~DATA_W'(16'hFFFF))
                        : (lane_data &  DATA_W'(16'hFFFF));
      2'd2: load_data = (sign_q && lane_data[31])
                        ? (lane_data | ~DATA_W'(32'hFFFF_FFFF))
                        : (lane_data &  DATA_W'(32'hFFFF_FFFF));
      default: load_data = lane_data;
    endcase
  end

`ifdef FAIRY_LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]  tmo_cnt;
  logic [ADDR_W-1:0] addr_q;

  assign tmo_hit    = ((state == ISSUE && !mem_gnt) || (state == WAIT && !mem_rvalid))
                      && (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign fault_addr = DATA_W'(addr_q);

  // idle-cycle counter; restarts whenever a new bus phase begins
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tmo_cnt <= '0;
    else if (state == IDLE || state == DRAIN || (state == ISSUE && mem_gnt))
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  // full address kept for the bus-error report
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      addr_q <= '0;
    else if (accept)
      addr_q <= in_addr;
  end
`else
  assign tmo_hit    = 1'b0;
  assign fault_addr = '0;
`endif

  // control FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_inst      <= '0;
      out_data      <= '0;
      out_unaligned <= 1'b0;
      out_buserr    <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_be        <= '0;
      mem_wdata     <= '0;
      load_q        <= 1'b0;
      sign_q        <= 1'b0;
      size_q        <= '0;
      lane_q        <= '0;
    end else begin
      if (flush || (out_valid && out_ready))
        out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            out_pc        <= in_pc;
            out_inst      <= in_inst;
            out_unaligned <= 1'b0;
            out_buserr    <= 1'b0;
            if (!is_mem) begin
              out_valid <= 1'b1;
              out_data  <= in_data;
            end else if (misaligned) begin
              out_valid     <= 1'b1;
              out_unaligned <= 1'b1;
              out_data      <= DATA_W'(in_addr);
            end else begin
              state     <= ISSUE;
              mem_req   <= 1'b1;
              mem_we    <= !in_load;
              mem_addr  <= {in_addr[ADDR_W-1:LSB], {LSB{1'b0}}};
              mem_be    <= be_n;
              mem_wdata <= wdata_n;
              load_q    <= in_load;
              sign_q    <= in_signed;
              size_q    <= in_size;
              lane_q    <= in_lane;
            end
          end
        end
        ISSUE: begin
          if (flush) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            // a granted load still returns data that must be swallowed
            state   <= (mem_gnt && load_q) ? DRAIN : IDLE;
          end else if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (load_q) begin
              state <= WAIT;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b1;
              out_data  <= '0;
            end
          end else if (tmo_hit) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            state      <= IDLE;
            out_valid  <= 1'b1;
            out_buserr <= 1'b1;
            out_data   <= fault_addr;
          end
        end
        WAIT: begin
          if (flush) begin
            state <= mem_rvalid ? IDLE : DRAIN;
          end else if (mem_rvalid) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            out_data  <= load_data;
          end else if (tmo_hit) begin
            state      <= IDLE;
            out_valid  <= 1'b1;
            out_buserr <= 1'b1;
            out_data   <= fault_addr;
          end
        end
        default: begin
          if (mem_rvalid)
            state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fairy_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_fairy_lsu
// Brief    : Self-checking bench for fairy_lsu (DATA_W=32, TIMEOUT=4):
//            directed scenarios followed by randomized operations checked
//            against an arithmetic reference model.
// Options  : FAIRY_LSU_TIMEOUT_EN selects the timeout expectations
// Revision : 1.0 - initial release
// ============================================================================
module tb_fairy_lsu;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int BYTES = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_pc = '0;
  logic [31:0]   in_inst = '0;
  logic          in_load = 1'b0;
  logic          in_store = 1'b0;
  logic [1:0]    in_size = '0;
  logic          in_signed = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_wdata = '0;
  logic [DW-1:0] in_data = '0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [BYTES-1:0] mem_be;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;
  logic [DW-1:0] out_data;
  logic          out_unaligned;
  logic          out_buserr;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_pc, exp_inst;

  fairy_lsu #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst),
    .in_load(in_load), .in_store(in_store), .in_size(in_size), .in_signed(in_signed),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_data(in_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_data(out_data), .out_unaligned(out_unaligned), .out_buserr(out_buserr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nb(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
    return (nb(sz) > BYTES) || ((int'(a[2:0]) % nb(sz)) != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    int lane = int'(a[1:0]);
    return 4'(((1 << nb(sz)) - 1) << lane);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int n = nb(sz);
    for (int i = 0; i < BYTES; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input bit sg,
                                         input logic [31:0] a, input logic [31:0] rd);
    int n = nb(sz);
    int lane = int'(a[1:0]);
    longint unsigned v, mask;
    if (n >= BYTES) return rd;
    v = 64'(rd) >> (8 * lane);
    mask = (64'd1 << (8 * n)) - 64'd1;
    v = v & mask;
    if (sg && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit ld, input bit st, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] alu);
    in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz; in_signed = sg;
    in_addr = a; in_wdata = wd; in_data = alu;
    exp_pc = $urandom; exp_inst = $urandom;
    in_pc = exp_pc; in_inst = exp_inst;
  endtask

  // one complete instruction with a scripted memory response
  task automatic do_op(input bit ld, input bit st, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] alu,
                       input int gd, input int rd, input logic [31:0] rdat,
                       input logic [31:0] exp_data);
    bit mem_op, mis;
    mem_op = ld || st;
    mis = mem_op && m_mis(sz, a);
    @(negedge clk);
    drive(ld, st, sz, sg, a, wd, alu);
    #1 check("in_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    if (!mem_op || mis) begin
      check("out_valid_n1", 32'(out_valid), 1);
      check("out_data_n1", out_data, exp_data);
      check("out_unaligned", 32'(out_unaligned), 32'(mis));
      check("no_mem_req", 32'(mem_req), 0);
    end else begin
      check("mem_req", 32'(mem_req), 1);
      check("mem_we", 32'(mem_we), 32'(st));
      check("mem_addr", mem_addr, {a[31:2], 2'b00});
      check("mem_be", 32'(mem_be), 32'(m_be(sz, a)));
      if (st) check("mem_wdata", mem_wdata, m_wdata(sz, wd));
      for (int i = 0; i < gd; i++) begin
        @(negedge clk);
        check("mem_req_held", 32'(mem_req), 1);
      end
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      check("mem_req_drop", 32'(mem_req), 0);
      if (ld) begin
        check("no_early_out", 32'(out_valid), 0);
        for (int i = 0; i < rd; i++) begin
          @(negedge clk);
          check("no_early_out", 32'(out_valid), 0);
        end
        mem_rvalid = 1'b1; mem_rdata = rdat;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = $urandom;
        check("load_data", out_data, exp_data);
      end
      check("out_valid_mem", 32'(out_valid), 1);
      check("out_unaligned_mem", 32'(out_unaligned), 0);
    end
    check("out_buserr", 32'(out_buserr), 0);
    check("out_pc", out_pc, exp_pc);
    check("out_inst", out_inst, exp_inst);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind, gd, rd;
    logic [1:0] sz;
    bit sg, ld, st;
    logic [31:0] a, wd, alu, rdat, expd;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_be", 32'(mem_be), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_flags", {30'd0, out_unaligned, out_buserr}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(in_ready), 1);

    // directed cases
    do_op(0, 0, 2'd2, 0, 32'h0, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 32'hCAFE_F00D);
    do_op(1, 0, 2'd0, 1, 32'h1003, 0, 0, 1, 0, 32'h80FF_FF00, 32'hFFFF_FF80);
    do_op(1, 0, 2'd0, 0, 32'h1003, 0, 0, 0, 2, 32'h80FF_FF00, 32'h0000_0080);
    do_op(0, 1, 2'd1, 0, 32'h2002, 32'h0000_1234, 0, 3, 0, 0, 0);
    do_op(1, 0, 2'd2, 0, 32'h3001, 0, 0, 0, 0, 0, 32'h0000_3001);
    do_op(1, 0, 2'd3, 0, 32'h3008, 0, 0, 0, 0, 0, 32'h0000_3008);

    // flush while load is waiting for data: the late response is dropped
    @(negedge clk); drive(1, 0, 2'd2, 0, 32'h4000, 0, 0);
    @(negedge clk); in_valid = 1'b0; check("fw_req", 32'(mem_req), 1); mem_gnt = 1'b1;
    @(negedge clk); mem_gnt = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0; check("fw_out0", 32'(out_valid), 0);
    @(negedge clk); mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); mem_rvalid = 1'b0; check("fw_out1", 32'(out_valid), 0);
    @(negedge clk); check("fw_out2", 32'(out_valid), 0);
    #1 check("fw_ready", 32'(in_ready), 1);
    do_op(1, 0, 2'd2, 0, 32'h4004, 0, 0, 0, 1, 32'h1111_1111, 32'h1111_1111);

    // flush before grant drops the request
    @(negedge clk); drive(1, 0, 2'd2, 0, 32'h4100, 0, 0);
    @(negedge clk); in_valid = 1'b0; check("fi_req", 32'(mem_req), 1); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check("fi_req_drop", 32'(mem_req), 0);
    check("fi_out", 32'(out_valid), 0);

    // flush wins over a simultaneous capture
    @(negedge clk); drive(0, 0, 2'd0, 0, 0, 0, 32'h0000_ABCD); flush = 1'b1;
    @(negedge clk); in_valid = 1'b0; flush = 1'b0;
    check("fc_out", 32'(out_valid), 0);

    // backpressure holds the result and blocks the next instruction
    out_ready = 1'b0;
    @(negedge clk); drive(0, 0, 2'd0, 0, 0, 0, 32'hA5A5_0001);
    @(negedge clk); drive(0, 0, 2'd0, 0, 0, 0, 32'hA5A5_0002);
    check("bp_valid", 32'(out_valid), 1);
    check("bp_data", out_data, 32'hA5A5_0001);
    #1 check("bp_ready", 32'(in_ready), 0);
    repeat (2) begin
      @(negedge clk);
      check("bp_hold", out_data, 32'hA5A5_0001);
      check("bp_ready_hold", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    check("bp_next", out_data, 32'hA5A5_0002);
    check("bp_next_valid", 32'(out_valid), 1);
    @(negedge clk); check("bp_drained", 32'(out_valid), 0);

    // flush clears a stalled result
    out_ready = 1'b0;
    @(negedge clk); drive(0, 0, 2'd0, 0, 0, 0, 32'h0000_0077);
    @(negedge clk); in_valid = 1'b0; check("fo_valid", 32'(out_valid), 1); flush = 1'b1;
    @(negedge clk); flush = 1'b0; check("fo_cleared", 32'(out_valid), 0);
    out_ready = 1'b1;

    // back-to-back non-memory ops at one per cycle
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        check("b2b_valid", 32'(out_valid), 1);
        check("b2b_data", out_data, 32'h0B0B_0000 + 32'(i - 1));
      end
      if (i < 3) begin
        drive(0, 0, 2'd0, 0, 0, 0, 32'h0B0B_0000 + 32'(i));
        @(negedge clk);
      end else begin
        in_valid = 1'b0;
      end
    end

    // reset during WAIT returns to IDLE at once
    @(negedge clk); drive(1, 0, 2'd2, 0, 32'h6000, 0, 0);
    @(negedge clk); in_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk); mem_gnt = 1'b0;
    #1 check("rw_wait_ready", 32'(in_ready), 0);
    reset = 1'b1;
    #1;
    check("rw_req", 32'(mem_req), 0);
    check("rw_out", 32'(out_valid), 0);
    check("rw_idle", 32'(in_ready), 1);
    @(negedge clk); reset = 1'b0;
    do_op(1, 0, 2'd1, 1, 32'h6002, 0, 0, 1, 0, 32'h8001_0000, 32'hFFFF_8001);

    // grant never arrives
    @(negedge clk); drive(0, 1, 2'd2, 0, 32'h5000, 32'h1234_5678, 0);
    @(negedge clk); in_valid = 1'b0; check("to_req", 32'(mem_req), 1);
`ifdef FAIRY_LSU_TIMEOUT_EN
    repeat (3) begin
      @(negedge clk);
      check("to_req_held", 32'(mem_req), 1);
      check("to_no_out", 32'(out_valid), 0);
    end
    @(negedge clk);
    check("to_valid", 32'(out_valid), 1);
    check("to_buserr", 32'(out_buserr), 1);
    check("to_addr", out_data, 32'h0000_5000);
    check("to_req_drop", 32'(mem_req), 0);
`else
    repeat (10) begin
      @(negedge clk);
      check("nto_req_held", 32'(mem_req), 1);
      check("nto_no_out", 32'(out_valid), 0);
    end
    mem_gnt = 1'b1;
    @(negedge clk); mem_gnt = 1'b0;
    check("nto_valid", 32'(out_valid), 1);
    check("nto_buserr", 32'(out_buserr), 0);
`endif

    // randomized operations against the reference model
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 2);
      sz   = 2'($urandom_range(0, 3));
      sg   = 1'($urandom_range(0, 1));
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nb(sz) - 1);
      wd   = $urandom;
      alu  = $urandom;
      rdat = $urandom;
      gd   = $urandom_range(0, 3);
      rd   = $urandom_range(0, 3);
      ld   = (kind == 1);
      st   = (kind == 2);
      if (kind == 0)        expd = alu;
      else if (m_mis(sz, a)) expd = a;
      else                  expd = m_load(sz, sg, a, rdat);
      do_op(ld, st, sz, sg, a, wd, alu, gd, rd, rdat, expd);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
